square_motion_ctrl: RTL and testbench

- Per-frame scheduler that moves the on-screen square across the 640x480 raster and generates its draw enable.
- Sits between the display timing generator (sx/sy) and the VGA output register stage. Replaces the fixed top-left square compare.
- Computes the next position once per frame, during vertical blanking, through a small FSM.
- Commits the new position atomically, so the square never tears mid-frame. It bounces off all four screen edges.

---
 rtl/square_motion_ctrl.sv | 165 ++++++++++++++++
 tb/tb_square_motion_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/square_motion_ctrl.sv
// Bouncing-square scheduler: advances the square once per frame inside vertical
// blanking, commits the new position atomically and registers the draw enable.
module square_motion_ctrl #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned SIZE   = 32,
  parameter int unsigned INIT_X = 0,
  parameter int unsigned INIT_Y = 0
) (
  input  logic        clk_pix,
  input  logic        rst_n,
  input  logic [10:0] sx,
  input  logic [9:0]  sy,
  input  logic        enable,
  input  logic [3:0]  speed,
  output logic [10:0] sq_x,
  output logic [9:0]  sq_y,
  output logic        dir_x,
  output logic        dir_y,
  output logic        q_draw,
  output logic        frame_tick,
  output logic        bounce
);

  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;
  localparam int unsigned CW = 12;
  localparam int unsigned SW = 4;

  localparam logic [CW-1:0] LIM_X  = CW'(H_RES - SIZE);
  localparam logic [CW-1:0] LIM_Y  = CW'(V_RES - SIZE);
  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);

  typedef enum logic [1:0] {S_WAIT, S_CALC_X, S_CALC_Y, S_COMMIT} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] spd_q, spd_d;
  logic [XW-1:0] nx_q, nx_d;
  logic [YW-1:0] ny_q, ny_d;
  logic          ndx_q, ndx_d;
  logic          ndy_q, ndy_d;
  logic [XW-1:0] sq_x_q, sq_x_d;
  logic [YW-1:0] sq_y_q, sq_y_d;
  logic          dir_x_q, dir_x_d;
  logic          dir_y_q, dir_y_d;
  logic          q_draw_q, q_draw_d;
  logic          frame_tick_q, frame_tick_d;
  logic          bounce_q, bounce_d;

  logic          trig_c;
  logic [CW:0]   x_step_c;
  logic [CW:0]   y_step_c;
  logic [CW-1:0] sx_w, sy_w, qx_w, qy_w;

  // One-axis move with edge clamp; returns {new_dir, new_pos}.
  function automatic logic [CW:0] axis_step(input logic [CW-1:0] pos,
                                            input logic          dir,
                                            input logic [CW-1:0] spd,
                                            input logic [CW-1:0] lim);
    logic [CW-1:0] t;
    logic [CW:0]   res;
    t = pos + spd;
    if (dir) begin
      res = (t > lim) ? {1'b0, lim} : {1'b1, t};
    end else begin
      res = (pos < spd) ? {1'b1, {CW{1'b0}}} : {1'b0, pos - spd};
    end
    return res;
  endfunction

  assign trig_c   = (sx == '0) && (sy == YW'(V_RES));
  assign x_step_c = axis_step(CW'(sq_x_q), dir_x_q, CW'(spd_q), LIM_X);
  assign y_step_c = axis_step(CW'(sq_y_q), dir_y_q, CW'(spd_q), LIM_Y);
  assign sx_w     = CW'(sx);
  assign sy_w     = CW'(sy);
  assign qx_w     = CW'(sq_x_q);
  assign qy_w     = CW'(sq_y_q);

  // Next-state and register-input logic; only COMMIT touches the visible position.
  always_comb begin
    state_d      = state_q;
    spd_d        = spd_q;
    nx_d         = nx_q;
    ny_d         = ny_q;
    ndx_d        = ndx_q;
    ndy_d        = ndy_q;
    sq_x_d       = sq_x_q;
    sq_y_d       = sq_y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    bounce_d     = 1'b0;
    frame_tick_d = trig_c;
    q_draw_d     = (sx_w >= qx_w) && (sx_w < qx_w + SIZE_C) &&
                   (sy_w >= qy_w) && (sy_w < qy_w + SIZE_C);

    unique case (state_q)
      S_WAIT: begin
        if (trig_c && enable) begin
          state_d = S_CALC_X;
          spd_d   = speed;
        end
      end
      S_CALC_X: begin
        state_d = S_CALC_Y;
        nx_d    = XW'(x_step_c[CW-1:0]);
        ndx_d   = x_step_c[CW];
      end
      S_CALC_Y: begin
        state_d = S_COMMIT;
        ny_d    = YW'(y_step_c[CW-1:0]);
        ndy_d   = y_step_c[CW];
      end
      S_COMMIT: begin
        state_d  = S_WAIT;
        sq_x_d   = nx_q;
        sq_y_d   = ny_q;
        dir_x_d  = ndx_q;
        dir_y_d  = ndy_q;
        bounce_d = (ndx_q != dir_x_q) || (ndy_q != dir_y_q);
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_WAIT;
      spd_q        <= '0;
      nx_q         <= '0;
      ny_q         <= '0;
      ndx_q        <= 1'b0;
      ndy_q        <= 1'b0;
      sq_x_q       <= XW'(INIT_X);
      sq_y_q       <= YW'(INIT_Y);
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      q_draw_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      bounce_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      spd_q        <= spd_d;
      nx_q         <= nx_d;
      ny_q         <= ny_d;
      ndx_q        <= ndx_d;
      ndy_q        <= ndy_d;
      sq_x_q       <= sq_x_d;
      sq_y_q       <= sq_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      q_draw_q     <= q_draw_d;
      frame_tick_q <= frame_tick_d;
      bounce_q     <= bounce_d;
    end
  end

  assign sq_x       = sq_x_q;
  assign sq_y       = sq_y_q;
  assign dir_x      = dir_x_q;
  assign dir_y      = dir_y_q;
  assign q_draw     = q_draw_q;
  assign frame_tick = frame_tick_q;
  assign bounce     = bounce_q;

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Scoreboard bench: two instances (640x480 and a square 480x480 field that moves
// diagonally in lock-step, used for corner bounces) share one stimulus stream.
module tb_square_motion_ctrl;

  localparam int NI   = 2;
  localparam int SZ   = 32;
  localparam int WIN  = 8;

  logic        clk_pix = 1'b0;
  logic        rst_n;
  logic [10:0] sx;
  logic [9:0]  sy;
  logic        enable;
  logic [3:0]  speed;

  logic [10:0] sq_x       [NI];
  logic [9:0]  sq_y       [NI];
  logic        dir_x      [NI];
  logic        dir_y      [NI];
  logic        q_draw     [NI];
  logic        frame_tick [NI];
  logic        bounce     [NI];

  typedef struct {
    int inst;
    int x;
    int y;
    int dx;
    int dy;
    int bnc;
  } exp_t;

  exp_t sb_q[$];

  int m_x  [NI];
  int m_y  [NI];
  int m_dx [NI];
  int m_dy [NI];
  int lim_x[NI];
  int lim_y[NI];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_pix = ~clk_pix;

  square_motion_ctrl u_dut0 (
    .clk_pix(clk_pix), .rst_n(rst_n), .sx(sx), .sy(sy),
    .enable(enable), .speed(speed),
    .sq_x(sq_x[0]), .sq_y(sq_y[0]), .dir_x(dir_x[0]), .dir_y(dir_y[0]),
    .q_draw(q_draw[0]), .frame_tick(frame_tick[0]), .bounce(bounce[0])
  );

  square_motion_ctrl #(.H_RES(480)) u_dut1 (
    .clk_pix(clk_pix), .rst_n(rst_n), .sx(sx), .sy(sy),
    .enable(enable), .speed(speed),
    .sq_x(sq_x[1]), .sq_y(sq_y[1]), .dir_x(dir_x[1]), .dir_y(dir_y[1]),
    .q_draw(q_draw[1]), .frame_tick(frame_tick[1]), .bounce(bounce[1])
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference move of one axis: clamp at the edge, flip only when overshooting.
  task automatic model_axis(input int p, input int d, input int s, input int lim,
                            output int np, output int nd);
    if (d != 0) begin
      if (p + s > lim) begin np = lim; nd = 0; end
      else             begin np = p + s; nd = 1; end
    end else begin
      if (p < s) begin np = 0;     nd = 1; end
      else       begin np = p - s; nd = 0; end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_dx[i] = 1; m_dy[i] = 1;
    end
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s u%0d sq_x", tag, i), int'(sq_x[i]), 0);
      check_eq($sformatf("%s u%0d sq_y", tag, i), int'(sq_y[i]), 0);
      check_eq($sformatf("%s u%0d dir_x", tag, i), int'(dir_x[i]), 1);
      check_eq($sformatf("%s u%0d dir_y", tag, i), int'(dir_y[i]), 1);
      check_eq($sformatf("%s u%0d q_draw", tag, i), int'(q_draw[i]), 0);
      check_eq($sformatf("%s u%0d frame_tick", tag, i), int'(frame_tick[i]), 0);
      check_eq($sformatf("%s u%0d bounce", tag, i), int'(bounce[i]), 0);
    end
  endtask

  // One frame: trigger, window of WIN cycles, then pop and compare the scoreboard.
  task automatic run_frame(input int en, input int spd, input int drop);
    int   ticks [NI];
    int   bncs  [NI];
    int   nx, ndx, ny, ndy;
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      e.inst = i; e.bnc = 0;
      if (en != 0) begin
        model_axis(m_x[i], m_dx[i], spd, lim_x[i], nx, ndx);
        model_axis(m_y[i], m_dy[i], spd, lim_y[i], ny, ndy);
        e.bnc  = (ndx != m_dx[i] || ndy != m_dy[i]) ? 1 : 0;
        m_x[i] = nx; m_dx[i] = ndx; m_y[i] = ny; m_dy[i] = ndy;
      end
      e.x = m_x[i]; e.y = m_y[i]; e.dx = m_dx[i]; e.dy = m_dy[i];
      sb_q.push_back(e);
      ticks[i] = 0; bncs[i] = 0;
    end
    sx = 11'd0; sy = 10'd480; enable = (en != 0); speed = 4'(spd);
    for (int c = 0; c < WIN; c++) begin
      @(posedge clk_pix); @(negedge clk_pix);
      for (int i = 0; i < NI; i++) begin
        ticks[i] += int'(frame_tick[i]);
        bncs[i]  += int'(bounce[i]);
      end
      if (c == 0) begin
        sx    = 11'd10;
        speed = ~speed;
        if (drop != 0) enable = 1'b0;
      end
    end
    for (int i = 0; i < NI; i++) begin
      e = sb_q.pop_front();
      check_eq($sformatf("u%0d sq_x", e.inst), int'(sq_x[e.inst]), e.x);
      check_eq($sformatf("u%0d sq_y", e.inst), int'(sq_y[e.inst]), e.y);
      check_eq($sformatf("u%0d dir_x", e.inst), int'(dir_x[e.inst]), e.dx);
      check_eq($sformatf("u%0d dir_y", e.inst), int'(dir_y[e.inst]), e.dy);
      check_eq($sformatf("u%0d bounce_cycles", e.inst), bncs[e.inst], e.bnc);
      check_eq($sformatf("u%0d frame_tick_cycles", e.inst), ticks[e.inst], 1);
    end
  endtask

  initial begin
    int px [6];
    int py [6];
    int bc [NI];
    int tc [NI];
    int exp_d;

    lim_x[0] = 608; lim_x[1] = 448;
    lim_y[0] = 448; lim_y[1] = 448;
    model_reset();
    rst_n = 1'b0; sx = 11'd10; sy = 10'd0; enable = 1'b0; speed = 4'd0;
    repeat (3) @(negedge clk_pix);
    check_reset("por");
    rst_n = 1'b1;
    repeat (3) @(negedge clk_pix);

    repeat (3) run_frame(1, 2, 0);
    repeat (31) run_frame(1, 14, 0);
    run_frame(1, 8, 0);
    run_frame(1, 15, 0);
    repeat (9) run_frame(1, 15, 0);
    run_frame(1, 8, 0);
    run_frame(1, 2, 0);
    run_frame(1, 4, 0);
    repeat (19) run_frame(1, 15, 0);
    run_frame(1, 11, 0);
    run_frame(1, 5, 0);

    repeat (2) run_frame(0, 7, 0);
    run_frame(1, 7, 1);
    run_frame(1, 0, 0);

    // Reset while the update is in CALC_Y.
    sx = 11'd0; sy = 10'd480; enable = 1'b1; speed = 4'd15;
    @(posedge clk_pix); @(negedge clk_pix);
    sx = 11'd10;
    @(posedge clk_pix); @(negedge clk_pix);
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    model_reset();
    @(negedge clk_pix); @(negedge clk_pix);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin bc[i] = 0; tc[i] = 0; end
    repeat (WIN) begin
      @(posedge clk_pix); @(negedge clk_pix);
      for (int i = 0; i < NI; i++) begin
        bc[i] += int'(bounce[i]);
        tc[i] += int'(frame_tick[i]);
      end
    end
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("post u%0d bounce_cycles", i), bc[i], 0);
      check_eq($sformatf("post u%0d frame_tick_cycles", i), tc[i], 0);
      check_eq($sformatf("post u%0d sq_x", i), int'(sq_x[i]), 0);
      check_eq($sformatf("post u%0d sq_y", i), int'(sq_y[i]), 0);
    end

    repeat (5) run_frame(1, 10, 0);

    // Draw-enable edges around the square at (50,50).
    px = '{50, 81, 82, 50, 49, 50};
    py = '{50, 81, 50, 49, 50, 82};
    for (int k = 0; k < 6; k++) begin
      sx = 11'(px[k]); sy = 10'(py[k]);
      @(posedge clk_pix); @(negedge clk_pix);
      for (int i = 0; i < NI; i++) begin
        exp_d = (px[k] >= m_x[i] && px[k] < m_x[i] + SZ &&
                 py[k] >= m_y[i] && py[k] < m_y[i] + SZ) ? 1 : 0;
        check_eq($sformatf("u%0d q_draw (%0d,%0d)", i, px[k], py[k]),
                 int'(q_draw[i]), exp_d);
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
